// File: rtl/fft_input_buffer.sv
// Serial-to-parallel frame buffer: collects D_WIDTH complex samples, then presents them as one frame; out_valid rises 1 cycle after the last accept.
// Backpressure: in_ready is low while a frame is held, until out_ready hands it off.
module fft_input_buffer #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int S_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [S_WIDTH-1:0] in_Re,
  input  logic [S_WIDTH-1:0] in_Im,
  output logic [S_WIDTH-1:0] output_sig_Re [D_WIDTH-1:0],
  output logic [S_WIDTH-1:0] output_sig_Im [D_WIDTH-1:0],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         frame_count
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

  state_t                 state;
  logic [LOG_2_WIDTH-1:0] wr_ptr;

  // Decoded from registered state only; no combinational path from in_valid or out_ready.
  assign in_ready = (state == FILL) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      out_valid   <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < D_WIDTH; i++) begin
        output_sig_Re[i] <= '0;
        output_sig_Im[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            output_sig_Re[wr_ptr] <= in_Re;
            output_sig_Im[wr_ptr] <= in_Im;
            if (wr_ptr == LAST_IDX) begin
              wr_ptr    <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        HOLD: begin
          // Frame stays frozen; in_valid is ignored because in_ready is low.
          if (out_ready) begin
            state       <= FILL;
            out_valid   <= 1'b0;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64, meaning the number of complex samples per frame.
REQ-002 SHALL have parameter LOG_2_WIDTH, default 6, meaning the sample-index width; log2(D_WIDTH).
REQ-003 SHALL have parameter S_WIDTH, default 16, meaning the bits per real or imaginary component.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1 is the clock, all state updates on the rising edge; rst input 1 is the synchronous active-high reset.
REQ-005 SHALL have in_valid input 1: the upstream sample is valid.
REQ-006 SHALL have in_ready output 1: the buffer accepts a sample this cycle.
REQ-007 SHALL have in_Re input S_WIDTH: the real part of the streamed sample.
REQ-008 SHALL have in_Im input S_WIDTH: the imaginary part of the streamed sample.
REQ-009 SHALL have output_sig_Re output [S_WIDTH-1:0] x [D_WIDTH-1:0], unpacked: the frame real parts, index = arrival order; feeds InputSignalRouter input_sig_Re.
REQ-010 SHALL have output_sig_Im output, same shape: the frame imaginary parts; feeds InputSignalRouter input_sig_Im.
REQ-011 SHALL have out_valid output 1: the parallel frame is complete and stable.
REQ-012 SHALL have out_ready input 1: the downstream stage consumes the frame.
REQ-013 SHALL have frame_count output 8: the number of frames handed off, modulo 256.

Function
REQ-014 SHALL implement two states: FILL (collecting samples) and HOLD (frame presented).
REQ-015 SHALL define in_ready = 1 in FILL and rst low, else 0, decoded combinationally from registered state only (no path from in_valid or out_ready).
REQ-016 SHALL keep a write index wr_ptr, LOG_2_WIDTH bits.
REQ-017 SHALL, in FILL on in_valid & in_ready, write in_Re/in_Im into entry wr_ptr and increment wr_ptr.
REQ-018 SHALL leave the buffer and wr_ptr unchanged in FILL when in_valid=0; gaps of any length are allowed.
REQ-019 SHALL, when the accepted write has wr_ptr = D_WIDTH-1, wrap wr_ptr to 0, enter HOLD, and raise out_valid on the next cycle.
REQ-020 SHALL make out_valid a registered output equal to (state == HOLD).
REQ-021 SHALL fix latency from last-sample acceptance edge to out_valid high at exactly 1 cycle.
REQ-022 SHALL, in HOLD, keep output_sig_Re/Im stable and ignore in_valid; no sample is accepted or lost, because in_ready=0.
REQ-023 SHALL, in HOLD with out_ready=1 at a clock edge, return to FILL, drop out_valid, and increment frame_count (255 wraps to 0).
REQ-024 SHALL ignore out_ready when out_valid=0.
REQ-025 SHALL make a new sample acceptable the cycle after handoff, giving a minimum frame period of D_WIDTH+1 cycles.
REQ-026 SHALL leave buffer entries of the previous frame visible on output_sig_Re/Im until overwritten; consumers SHALL sample only while out_valid=1.
REQ-027 SHALL store samples unmodified: no sign extension, scaling, or reordering; bit reversal belongs to the router.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set state=FILL, wr_ptr=0, out_valid=0, frame_count=0, and clear all buffer entries to 0.
REQ-029 SHALL make rst override all other inputs, including in_valid and out_ready in the same cycle.
REQ-030 SHALL, on reset mid-frame (FILL, wr_ptr≠0) or in HOLD, discard the partial or pending frame with no handoff and no frame_count increment.
REQ-031 SHALL hold in_ready=0 while rst=1, and the first sample SHALL be accepted on the first edge with rst=0 and in_valid=1.

Verification
REQ-032 Bench SHALL cover: reset then stream samples Re=i, Im=63-i for i=0..63 with continuous in_valid -> out_valid rises 1 cycle after the 64th accept; output_sig_Re[k]=k, output_sig_Im[k]=63-k; in_ready=0.
REQ-033 Bench SHALL cover: the same stream with in_valid toggling 1/0 each cycle -> identical frame contents; out_valid only after 64 accepts (~128 cycles).
REQ-034 Bench SHALL cover: frame full, out_ready held 0 for 20 cycles while in_valid=1 with Re=16'hFFFF -> outputs unchanged, in_ready=0, frame_count unchanged; then out_ready=1 for 1 cycle -> out_valid=0, frame_count=1, in_ready=1.
REQ-035 Bench SHALL cover: rst asserted after 30 samples -> wr_ptr=0, outputs all 0, out_valid=0; then a full 64-sample frame -> correct contents, frame_count=1 after handoff.
REQ-036 Bench SHALL cover: 257 back-to-back frames with out_ready tied 1 -> each frame period is 65 cycles; frame_count reads 1 after frame 257 (wrap).
REQ-037 Bench SHALL cover: connect to InputSignalRouter (D_WIDTH=64, LOG_2_WIDTH=6), stream 0..63 -> router outputs match the router's expected permutation while out_valid=1.
